// File: rtl/cga_intr_pkg.sv
// Shared types and constants for the CGA interrupt level scheduler.
package cga_intr_pkg;

    localparam int unsigned NLVL  = 16;
    localparam int unsigned LVL_W = 4;

    // Register addresses decoded from LAA_3_0
    localparam logic [3:0] LAA_PIE = 4'h5;
    localparam logic [3:0] LAA_PID = 4'h6;
    localparam logic [3:0] LAA_PIL = 4'h7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_SETTLE = 2'd2
    } lvlState_t;

endpackage

// File: rtl/cga_intr_prienc.sv
// Highest-set-bit encoder: returns index of the most significant set bit.
module cga_intr_prienc
    import cga_intr_pkg::*;
(
    input  logic [NLVL-1:0]  vec,
    output logic [LVL_W-1:0] idx,
    output logic             valid
);

    // Ascending scan so the last (highest) set bit wins
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < NLVL; i++) begin
            if (vec[i]) begin
                idx   = LVL_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cga_intr_lvlsched.sv
// Interrupt level scheduler: PIE/PID/PIL/PVL registers and the
// level-change request/acknowledge handshake with the microcode.
module cga_intr_lvlsched
    import cga_intr_pkg::*;
(
    input  logic             MCLK,
    input  logic             RESETN,
    input  logic [NLVL-1:0]  IREQ_15_0_N,
    input  logic [NLVL-1:0]  FIDBO_15_0,
    input  logic [3:0]       LAA_3_0,
    input  logic             WRN,
    input  logic             IONI,
    input  logic             LVLACK,
    output logic [NLVL-1:0]  PIE_15_0,
    output logic [NLVL-1:0]  PID_15_0,
    output logic [LVL_W-1:0] PIL_3_0,
    output logic [LVL_W-1:0] PVL_3_0,
    output logic             LVLREQ,
    output logic [LVL_W-1:0] NEWLVL_3_0
);

    lvlState_t        state;
    logic             pieWrite;
    logic             pidWrite;
    logic             pilWrite;
    logic             ackTake;
    logic [LVL_W-1:0] cand;
    logic             cvalid;
    logic             go;

    assign pieWrite = ~WRN & (LAA_3_0 == LAA_PIE);
    assign pidWrite = ~WRN & (LAA_3_0 == LAA_PID);
    assign pilWrite = ~WRN & (LAA_3_0 == LAA_PIL);

    // A PIL write in the same edge overrides the acknowledge
    assign ackTake  = (state == ST_REQ) & LVLACK & ~pilWrite;

    cga_intr_prienc uPrienc (
        .vec   (PID_15_0 & PIE_15_0),
        .idx   (cand),
        .valid (cvalid)
    );

    // Level 0 is never requested because cand must exceed PIL
    assign go = IONI & cvalid & (cand > PIL_3_0);

    // Enable and detect registers; new requests survive a PID write
    always_ff @(posedge MCLK or negedge RESETN) begin
        if (!RESETN) begin
            PIE_15_0 <= '0;
            PID_15_0 <= '0;
        end else begin
            if (pieWrite) begin
                PIE_15_0 <= FIDBO_15_0;
            end
            PID_15_0 <= (pidWrite ? FIDBO_15_0 : PID_15_0) | ~IREQ_15_0_N;
        end
    end

    // Current/previous program level: microcode write or accepted change
    always_ff @(posedge MCLK or negedge RESETN) begin
        if (!RESETN) begin
            PIL_3_0 <= '0;
            PVL_3_0 <= '0;
        end else if (pilWrite) begin
            PVL_3_0 <= PIL_3_0;
            PIL_3_0 <= FIDBO_15_0[LVL_W-1:0];
        end else if (ackTake) begin
            PVL_3_0 <= PIL_3_0;
            PIL_3_0 <= NEWLVL_3_0;
        end
    end

    // Level-change handshake sequencer with registered LVLREQ/NEWLVL
    always_ff @(posedge MCLK or negedge RESETN) begin
        if (!RESETN) begin
            state      <= ST_IDLE;
            LVLREQ     <= 1'b0;
            NEWLVL_3_0 <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        state      <= ST_REQ;
                        LVLREQ     <= 1'b1;
                        NEWLVL_3_0 <= cand;
                    end
                end
                ST_REQ: begin
                    if (pilWrite) begin
                        state  <= ST_IDLE;
                        LVLREQ <= 1'b0;
                    end else if (LVLACK) begin
                        state  <= ST_SETTLE;
                        LVLREQ <= 1'b0;
                    end else if (!IONI) begin
                        state  <= ST_IDLE;
                        LVLREQ <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    // One quiet cycle so the compare sees the new PIL
                    state  <= ST_IDLE;
                    LVLREQ <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    LVLREQ <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cga_intr_lvlsched.sv
// Bench for the interrupt level scheduler: directed vector table,
// hand-written corner sequences and randomized stimulus vs. a model.
module tb_cga_intr_lvlsched;
    import cga_intr_pkg::*;

    logic        MCLK;
    logic        RESETN;
    logic [15:0] IREQ_15_0_N;
    logic [15:0] FIDBO_15_0;
    logic [3:0]  LAA_3_0;
    logic        WRN;
    logic        IONI;
    logic        LVLACK;
    logic [15:0] PIE_15_0;
    logic [15:0] PID_15_0;
    logic [3:0]  PIL_3_0;
    logic [3:0]  PVL_3_0;
    logic        LVLREQ;
    logic [3:0]  NEWLVL_3_0;

    cga_intr_lvlsched dut (
        .MCLK        (MCLK),
        .RESETN      (RESETN),
        .IREQ_15_0_N (IREQ_15_0_N),
        .FIDBO_15_0  (FIDBO_15_0),
        .LAA_3_0     (LAA_3_0),
        .WRN         (WRN),
        .IONI        (IONI),
        .LVLACK      (LVLACK),
        .PIE_15_0    (PIE_15_0),
        .PID_15_0    (PID_15_0),
        .PIL_3_0     (PIL_3_0),
        .PVL_3_0     (PVL_3_0),
        .LVLREQ      (LVLREQ),
        .NEWLVL_3_0  (NEWLVL_3_0)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    int checks   = 0;
    int failures = 0;

    // Reference model: architectural registers plus handshake phase flags
    logic [15:0] mPie, mPid;
    logic [3:0]  mPil, mPvl, mNew;
    bit          mReq, mSettle;

    typedef struct {
        logic [15:0] ireqn;
        logic [15:0] fidbo;
        logic [3:0]  laa;
        logic        wrn;
        logic        ioni;
        logic        ack;
        logic [15:0] ePie;
        logic [15:0] ePid;
        logic [3:0]  ePil;
        logic [3:0]  ePvl;
        logic        eReq;
        logic [3:0]  eNew;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mReset();
        mPie = '0; mPid = '0; mPil = '0; mPvl = '0; mNew = '0;
        mReq = 0; mSettle = 0;
    endtask

    // Advance the model by one clock edge using the applied inputs
    task automatic mUpdate(input logic [15:0] ireqn, input logic [15:0] fidbo,
                           input logic [3:0] laa, input logic wrn,
                           input logic ioni, input logic ack);
        int  cand;
        bit  found;
        bit  pilW;
        bit  go;
        found = 0;
        cand  = 0;
        for (int n = 15; n >= 0; n--) begin
            if (!found && mPid[n] && mPie[n]) begin
                found = 1;
                cand  = n;
            end
        end
        pilW = !wrn && (laa == 4'h7);
        go   = ioni && found && (cand > int'(mPil));
        if (pilW) begin
            mPvl = mPil;
            mPil = fidbo[3:0];
        end else if (mReq && ack) begin
            mPvl = mPil;
            mPil = mNew;
        end
        if (mReq) begin
            if (pilW) mReq = 0;
            else if (ack) begin
                mReq    = 0;
                mSettle = 1;
            end else if (!ioni) mReq = 0;
        end else if (mSettle) begin
            mSettle = 0;
        end else if (go) begin
            mReq = 1;
            mNew = 4'(cand);
        end
        mPid = ((!wrn && laa == 4'h6) ? fidbo : mPid) | ~ireqn;
        if (!wrn && laa == 4'h5) mPie = fidbo;
    endtask

    task automatic checkModel(input string tag);
        check({tag, ".pie"},    int'(PIE_15_0),   int'(mPie));
        check({tag, ".pid"},    int'(PID_15_0),   int'(mPid));
        check({tag, ".pil"},    int'(PIL_3_0),    int'(mPil));
        check({tag, ".pvl"},    int'(PVL_3_0),    int'(mPvl));
        check({tag, ".lvlreq"}, int'(LVLREQ),     int'(mReq));
        if (mReq) check({tag, ".newlvl"}, int'(NEWLVL_3_0), int'(mNew));
    endtask

    // Drive inputs, clock one edge, update model, sample #1 after the edge
    task automatic step(input logic [15:0] ireqn, input logic [15:0] fidbo,
                        input logic [3:0] laa, input logic wrn,
                        input logic ioni, input logic ack, input string tag);
        IREQ_15_0_N = ireqn; FIDBO_15_0 = fidbo; LAA_3_0 = laa;
        WRN = wrn; IONI = ioni; LVLACK = ack;
        @(posedge MCLK);
        mUpdate(ireqn, fidbo, laa, wrn, ioni, ack);
        #1;
        checkModel(tag);
    endtask

    function automatic vec_t mk(input logic [15:0] ireqn, input logic [15:0] fidbo,
                                input logic [3:0] laa, input logic wrn,
                                input logic ioni, input logic ack,
                                input logic [15:0] ePie, input logic [15:0] ePid,
                                input logic [3:0] ePil, input logic [3:0] ePvl,
                                input logic eReq, input logic [3:0] eNew);
        vec_t v;
        v.ireqn = ireqn; v.fidbo = fidbo; v.laa = laa; v.wrn = wrn;
        v.ioni = ioni; v.ack = ack; v.ePie = ePie; v.ePid = ePid;
        v.ePil = ePil; v.ePvl = ePvl; v.eReq = eReq; v.eNew = eNew;
        return v;
    endfunction

    task automatic doReset();
        RESETN = 1'b0;
        IREQ_15_0_N = 16'hFFFF; FIDBO_15_0 = '0; LAA_3_0 = '0;
        WRN = 1'b1; IONI = 1'b0; LVLACK = 1'b0;
        mReset();
        repeat (2) @(posedge MCLK);
        @(negedge MCLK);
        RESETN = 1'b1;
    endtask

    initial begin
        //                 ireqn     fidbo     laa  wrn ioni ack   pie       pid      pil   pvl  req new
        tbl[0]  = mk(16'hFFFF, 16'h0400, 4'h5, 0, 1, 0, 16'h0400, 16'h0000, 4'd0,  4'd0,  0, 4'd0);
        tbl[1]  = mk(16'hFBFF, 16'h0000, 4'h0, 1, 1, 0, 16'h0400, 16'h0400, 4'd0,  4'd0,  0, 4'd0);
        tbl[2]  = mk(16'hFFFF, 16'h0000, 4'h0, 1, 1, 0, 16'h0400, 16'h0400, 4'd0,  4'd0,  1, 4'd10);
        tbl[3]  = mk(16'hFFFF, 16'h0000, 4'h0, 1, 1, 1, 16'h0400, 16'h0400, 4'd10, 4'd0,  0, 4'd10);
        tbl[4]  = mk(16'hFFFF, 16'h0000, 4'h0, 1, 1, 0, 16'h0400, 16'h0400, 4'd10, 4'd0,  0, 4'd10);
        tbl[5]  = mk(16'hFFFF, 16'hFFFF, 4'h5, 0, 1, 0, 16'hFFFF, 16'h0400, 4'd10, 4'd0,  0, 4'd10);
        tbl[6]  = mk(16'hFFFF, 16'h0402, 4'h6, 0, 1, 0, 16'hFFFF, 16'h0402, 4'd10, 4'd0,  0, 4'd10);
        tbl[7]  = mk(16'hFFFF, 16'h0000, 4'h0, 1, 1, 0, 16'hFFFF, 16'h0402, 4'd10, 4'd0,  0, 4'd10);
        tbl[8]  = mk(16'hFFFF, 16'h0000, 4'h7, 0, 1, 0, 16'hFFFF, 16'h0402, 4'd0,  4'd10, 0, 4'd10);
        tbl[9]  = mk(16'hFFFF, 16'h0000, 4'h0, 1, 1, 0, 16'hFFFF, 16'h0402, 4'd0,  4'd10, 1, 4'd10);
        tbl[10] = mk(16'hFFFF, 16'h0000, 4'h0, 1, 1, 1, 16'hFFFF, 16'h0402, 4'd10, 4'd0,  0, 4'd10);
        tbl[11] = mk(16'hFFFF, 16'h0000, 4'h0, 1, 1, 0, 16'hFFFF, 16'h0402, 4'd10, 4'd0,  0, 4'd10);

        doReset();
        #1;
        check("rst.pie",    int'(PIE_15_0),   0);
        check("rst.pid",    int'(PID_15_0),   0);
        check("rst.pil",    int'(PIL_3_0),    0);
        check("rst.pvl",    int'(PVL_3_0),    0);
        check("rst.lvlreq", int'(LVLREQ),     0);
        check("rst.newlvl", int'(NEWLVL_3_0), 0);

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            IREQ_15_0_N = tbl[i].ireqn; FIDBO_15_0 = tbl[i].fidbo; LAA_3_0 = tbl[i].laa;
            WRN = tbl[i].wrn; IONI = tbl[i].ioni; LVLACK = tbl[i].ack;
            @(posedge MCLK);
            mUpdate(tbl[i].ireqn, tbl[i].fidbo, tbl[i].laa, tbl[i].wrn, tbl[i].ioni, tbl[i].ack);
            #1;
            check($sformatf("tbl%0d.pie", i),    int'(PIE_15_0), int'(tbl[i].ePie));
            check($sformatf("tbl%0d.pid", i),    int'(PID_15_0), int'(tbl[i].ePid));
            check($sformatf("tbl%0d.pil", i),    int'(PIL_3_0),  int'(tbl[i].ePil));
            check($sformatf("tbl%0d.pvl", i),    int'(PVL_3_0),  int'(tbl[i].ePvl));
            check($sformatf("tbl%0d.lvlreq", i), int'(LVLREQ),   int'(tbl[i].eReq));
            if (tbl[i].eReq) check($sformatf("tbl%0d.newlvl", i), int'(NEWLVL_3_0), int'(tbl[i].eNew));
        end

        // NEWLVL frozen during REQ, re-request after SETTLE
        doReset();
        step(16'hFFFF, 16'hFFFF, 4'h5, 0, 1, 0, "frz.pie");
        step(16'hFFFF, 16'h0020, 4'h6, 0, 1, 0, "frz.pid");
        step(16'hFFFF, 16'h0000, 4'h0, 1, 1, 0, "frz.req");
        check("frz.req5", int'(NEWLVL_3_0), 5);
        step(16'hEFFF, 16'h0000, 4'h0, 1, 1, 0, "frz.hi");
        check("frz.stay5", int'(NEWLVL_3_0), 5);
        check("frz.stayreq", int'(LVLREQ), 1);
        step(16'hFFFF, 16'h0000, 4'h0, 1, 1, 1, "frz.ack");
        check("frz.pil5", int'(PIL_3_0), 5);
        step(16'hFFFF, 16'h0000, 4'h0, 1, 1, 0, "frz.settle");
        check("frz.settlereq", int'(LVLREQ), 0);
        step(16'hFFFF, 16'h0000, 4'h0, 1, 1, 0, "frz.rereq");
        check("frz.new12", int'(NEWLVL_3_0), 12);
        check("frz.req12", int'(LVLREQ), 1);

        // IONI withdrawn during REQ, then restored
        step(16'hFFFF, 16'h0000, 4'h0, 1, 0, 0, "ioni.drop");
        check("ioni.dropreq", int'(LVLREQ), 0);
        check("ioni.pil", int'(PIL_3_0), 5);
        step(16'hFFFF, 16'h0000, 4'h0, 1, 0, 0, "ioni.off");
        step(16'hFFFF, 16'h0000, 4'h0, 1, 1, 0, "ioni.on");
        check("ioni.rereq", int'(LVLREQ), 1);

        // PIL write beats LVLACK; request survives PID write
        step(16'hFFFF, 16'h0007, 4'h7, 0, 1, 1, "pri.pilack");
        check("pri.pil7", int'(PIL_3_0), 7);
        check("pri.pvl5", int'(PVL_3_0), 5);
        check("pri.req0", int'(LVLREQ), 0);
        step(16'hFFF7, 16'h0000, 4'h6, 0, 1, 0, "pri.pidw");
        check("pri.pid8", int'(PID_15_0), 16'h0008);

        // Asynchronous reset while a request is pending
        step(16'hFFFF, 16'h0000, 4'h7, 0, 1, 0, "arst.pil0");
        step(16'hFFFF, 16'h0000, 4'h0, 1, 1, 0, "arst.req");
        check("arst.inreq", int'(LVLREQ), 1);
        #3;
        RESETN = 1'b0;
        #1;
        check("arst.pie",    int'(PIE_15_0),   0);
        check("arst.pid",    int'(PID_15_0),   0);
        check("arst.pil",    int'(PIL_3_0),    0);
        check("arst.pvl",    int'(PVL_3_0),    0);
        check("arst.lvlreq", int'(LVLREQ),     0);
        check("arst.newlvl", int'(NEWLVL_3_0), 0);
        mReset();
        @(negedge MCLK);
        RESETN = 1'b1;

        // Randomized stimulus against the model
        for (int c = 0; c < 3000; c++) begin
            logic [15:0] rq;
            rq = ($urandom_range(0, 5) == 0) ? (16'h0001 << $urandom_range(0, 15)) : 16'h0000;
            step(~rq, 16'($urandom), 4'($urandom_range(4, 8)),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) != 0),
                 1'($urandom_range(0, 1)), $sformatf("rnd%0d", c));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cga_intr_lvlsched.md
# cga_intr_lvlsched

Interrupt level scheduler for the CGA interrupt subsystem. It holds the 16-level priority-interrupt enable (PIE) and detect (PID) registers and latches the active-low level requests from the interrupt source block into PID. It selects the highest enabled pending level and sequences a level-change request/acknowledge handshake with the microcode, tracking the current (PIL) and previous (PVL) program levels. It sits between the interrupt source/controller logic and the microsequencer.

## Interface
Parameters:
- NLVL, 16, number of priority levels (fixed at 16 in this design)
- LVL_W, 4, level index width, clog2(NLVL)

Ports:
- MCLK  in  1  master clock; all state changes on rising edge
- RESETN  in  1  asynchronous, active-low reset
- IREQ_15_0_N  in  16  active-low level requests; bit n low sets PID[n]
- FIDBO_15_0  in  16  register write data
- LAA_3_0  in  4  register address: 4'h5=PIE, 4'h6=PID, 4'h7=PIL
- WRN  in  1  active-low write strobe, one MCLK per write
- IONI  in  1  interrupt system on; 0 suppresses level requests
- LVLACK  in  1  microcode accepts pending level change
- PIE_15_0  out  16  enable register
- PID_15_0  out  16  detect register
- PIL_3_0  out  4  current program level
- PVL_3_0  out  4  previous program level
- LVLREQ  out  1  level change requested
- NEWLVL_3_0  out  4  requested level, valid while LVLREQ=1

## Operation
- Reset values: PIE=0, PID=0, PIL=0, PVL=0, LVLREQ=0, NEWLVL=0, FSM=IDLE.
- PID update per edge: PID <= (WRN=0 and LAA=6 ? FIDBO : PID) | ~IREQ_N. A request arriving in the same cycle as a PID write survives the write.
- PIE write: LAA=5, WRN=0 → PIE <= FIDBO.
- PIL write: LAA=7, WRN=0 → PVL <= PIL, PIL <= FIDBO[3:0]. This path handles level return.
- Writes with any other LAA value are ignored.
- Candidate: the highest index n with PID[n] & PIE[n]; cvalid=1 if any such n exists.
- Request condition: go = IONI & cvalid & (cand > PIL). Level 0 can never be requested.
- FSM states:
  - IDLE: if go → REQ; NEWLVL <= cand (frozen).
  - REQ: LVLREQ=1.
    - LVLACK=1 → PVL <= PIL, PIL <= NEWLVL; → SETTLE.
    - Otherwise, IONI=0 → IDLE (request withdrawn).
    - A new higher candidate during REQ does not alter NEWLVL.
  - SETTLE: LVLREQ=0 for one cycle, then → IDLE. This lets the compare see the new PIL.
- Priority within one edge: a PIL write beats LVLACK. In REQ or SETTLE, a PIL write forces → IDLE, drops LVLREQ, and the ack is discarded.
- LVLACK outside REQ is ignored.
- PID bits are never auto-cleared. Microcode clears them by writing PID.
- Reset mid-handshake: everything returns to reset values immediately (asynchronous).

## Timing
- IREQ_N[n] low sampled at edge k → PID[n]=1 after k.
- LVLREQ=1 and NEWLVL valid after edge k+1. Latency is 2 edges from request to LVLREQ.
- LVLACK sampled at edge j → PIL/PVL updated and LVLREQ=0 after j. The earliest re-request is after j+2 (SETTLE occupies j+1).
- Register writes take effect at the edge where WRN is sampled low. Outputs are all registered except for none: every output comes straight from a flop.

## Structure
- Package cga_intr_pkg holds:
  - FSM state enum (IDLE, REQ, SETTLE)
  - LAA constants for PIE/PID/PIL
  - LVL_W, NLVL
- Sub-module cga_intr_prienc: combinational 16→4 highest-set-bit encoder with valid output, instantiated once on PID&PIE.

## Test plan
- Reset, then PIE=16'h0400, IONI=1, pulse IREQ_N[10] low for 1 cycle → PID=16'h0400, LVLREQ=1 and NEWLVL=10 two edges later. LVLACK → PIL=10, PVL=0, LVLREQ=0.
- PIL=10 and PID=16'h0402 with PIE=16'hFFFF → no request (level 1 < 10). Write PIL=0 → LVLREQ with NEWLVL=10 two edges later.
- During REQ with NEWLVL=5, set PID[12] → NEWLVL stays 5. After ack (PIL=5) and SETTLE, LVLREQ reasserts with NEWLVL=12.
- IONI dropped during REQ → LVLREQ=0 next edge, PIL unchanged. Restoring IONI → request reasserts.
- Same-cycle PID write 16'h0000 and IREQ_N[3] low → PID=16'h0008. Same-cycle PIL write 7 and LVLACK in REQ → PIL=7, FSM=IDLE.
- Assert RESETN low asynchronously mid-REQ → all outputs 0 without a clock edge.
